// File: rtl/fetch_step_ctrl_pkg.sv
// Shared PC-source encodings and helpers for the fetch/next-PC stage.
package fetch_step_ctrl_pkg;

    localparam int unsigned XLEN = 32;

    // Next-PC source select, shared with the control unit
    localparam logic [1:0] PCSRC_P4 = 2'b00;
    localparam logic [1:0] PCSRC_BR = 2'b01;
    localparam logic [1:0] PCSRC_JR = 2'b10;
    localparam logic [1:0] PCSRC_J  = 2'b11;

    // Debounced button state
    typedef enum logic {
        DB_RELEASED = 1'b0,
        DB_PRESSED  = 1'b1
    } db_state_e;

    // Sign-extended word offset of a branch, in bytes
    function automatic logic [XLEN-1:0] branch_disp(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

    // Jump target within the current 256 MB region
    function automatic logic [XLEN-1:0] jump_target(input logic [XLEN-1:0] pc4,
                                                   input logic [25:0]      idx);
        return {pc4[31:28], idx, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_step_ctrl_debounce.sv
// Push-button synchroniser and debouncer producing a level and a rising-edge pulse.
module btn_debounce
    import fetch_step_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic clrn,
    input  logic btn_raw,
    output logic level,
    output logic rise_pulse
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             btn_sync;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_d;

    assign btn_sync = sync_q[1];
    assign level    = (state_q == DB_PRESSED);

    // Two-flop synchroniser for the asynchronous button
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) sync_q <= 2'b00;
        else       sync_q <= {sync_q[0], btn_raw};
    end

    // Debounce state, stability counter and edge pulse registers
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= DB_RELEASED;
            cnt_q      <= '0;
            rise_pulse <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rise_pulse <= rise_d;
        end
    end

    // Accept a new level only after it has been stable for the full window
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        case (state_q)
            DB_RELEASED: begin
                if (btn_sync) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = DB_PRESSED;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DB_PRESSED: begin
                if (!btn_sync) begin
                    if (cnt_q == CNT_LAST) state_d = DB_RELEASED;
                    else                   cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = DB_RELEASED;
        endcase
    end

endmodule

// File: rtl/fetch_step_ctrl.sv
// Next-PC select and fetch pacing: auto-run ticks or debounced single steps.
module fetch_step_ctrl
    import fetch_step_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned RUN_DIV         = 100_000_000,
    parameter logic [31:0] PC_RESET        = 32'h0000_0000,
    parameter int unsigned ADDR_W          = 6
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              run_mode,
    input  logic              step_btn,
    input  logic              halt,
    input  logic [1:0]        pcsource,
    input  logic [31:0]       inst,
    input  logic [31:0]       ra,
    output logic [31:0]       pc,
    output logic [31:0]       pc4,
    output logic [ADDR_W-1:0] irom_addr,
    output logic              advance,
    output logic [15:0]       step_count
);

    localparam int unsigned     TICK_W    = $clog2(RUN_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RUN_DIV - 1);

    logic              btn_level;
    logic              step_pulse;
    logic [TICK_W-1:0] tick_cnt_q;
    logic              tick;
    logic              adv_req;
    logic              adv_go;
    logic [31:0]       next_pc;
    logic              unused_bits;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .clrn      (clrn),
        .btn_raw   (step_btn),
        .level     (btn_level),
        .rise_pulse(step_pulse)
    );

    assign unused_bits = ^{inst[31:26], btn_level};

    assign pc4       = pc + 32'd4;
    assign irom_addr = pc[ADDR_W+1:2];
    assign tick      = (tick_cnt_q == TICK_LAST);
    assign adv_req   = run_mode ? tick : step_pulse;
    assign adv_go    = adv_req & ~halt;

    // Auto-run divider, held at zero outside run mode
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)                 tick_cnt_q <= '0;
        else if (!run_mode || tick) tick_cnt_q <= '0;
        else                       tick_cnt_q <= tick_cnt_q + TICK_W'(1);
    end

    // Next-PC select from the values present in the advancing cycle
    always_comb begin
        next_pc = pc4;
        case (pcsource)
            PCSRC_P4: next_pc = pc4;
            PCSRC_BR: next_pc = pc4 + branch_disp(inst[15:0]);
            PCSRC_JR: next_pc = ra;
            PCSRC_J:  next_pc = jump_target(pc4, inst[25:0]);
            default:  next_pc = pc4;
        endcase
    end

    // PC, advance pulse and saturating retired-instruction counter
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pc         <= PC_RESET;
            advance    <= 1'b0;
            step_count <= '0;
        end else begin
            advance <= adv_go;
            if (adv_go) begin
                pc <= next_pc;
                if (step_count != 16'hFFFF) step_count <= step_count + 16'd1;
            end
        end
    end

endmodule
